sm_subtractor_q22: RTL and testbench

- Pipelined sign-magnitude subtractor computing c = a - b on 5-bit sign-magnitude Q2.2 operands.
- Result is 6-bit sign-magnitude Q3.2, the same result format the team's Q2.2 adder produces, so downstream logic can take results from either block unchanged.
- Two-stage pipeline with valid/ready handshakes on input and output, full throughput (1 op/cycle), and backpressure support.
- Sits in the Q2.2 arithmetic datapath, paired with the adder, to provide the subtraction direction.

---
 rtl/sm_subtractor_q22.sv | 138 +++++++++++++
 tb/tb_sm_subtractor_q22.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sm_subtractor_q22.sv
// -----------------------------------------------------------------------------
// sm_subtractor_q22
//
// Two-stage pipelined sign-magnitude subtractor, c = a - b.
//   Operands : 5-bit sign-magnitude Q2.2 (bit 4 = sign, bits 3:0 = magnitude,
//              value = magnitude / 4, range -3.75 .. +3.75).
//   Result   : 6-bit sign-magnitude Q3.2 (bit 5 = sign, bits 4:0 = magnitude,
//              value = magnitude / 4, range -7.5 .. +7.5). This matches the
//              result format of the Q2.2 adder, so consumers can mix the two.
//
// Stage 1 converts both operands to 6-bit two's complement, with b negated.
// Stage 2 adds them and converts the sum back to sign-magnitude. A zero sum
// always encodes as +0, and a -0 operand behaves exactly like +0.
//
// Both stages advance under valid/ready handshakes. The pipeline sustains one
// operation per cycle and holds its contents losslessly under backpressure.
//
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous reset, active high
//   in_valid   in   1  operand pair a/b is valid
//   in_ready   out  1  block can accept an operand pair this cycle
//   a          in   5  minuend, sign-magnitude Q2.2
//   b          in   5  subtrahend, sign-magnitude Q2.2
//   out_valid  out  1  result c is valid
//   out_ready  in   1  downstream accepts c this cycle
//   c          out  6  difference, sign-magnitude Q3.2
// -----------------------------------------------------------------------------
module sm_subtractor_q22 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] c
);

  // ---------------------------------------------------------------------------
  // Format conversion helpers
  // ---------------------------------------------------------------------------

  // Sign-magnitude Q2.2 to 6-bit two's complement. When negate is set the
  // sign is flipped first, which is how the subtrahend becomes an addend.
  // A magnitude of zero yields zero whatever the sign, so -0 is harmless.
  function automatic logic [5:0] sm_to_tc(input logic [4:0] sm, input logic negate);
    logic [5:0] mag_ext;
    logic       neg;
    mag_ext = {2'b00, sm[3:0]};
    neg     = sm[4] ^ negate;
    return neg ? (~mag_ext + 6'd1) : mag_ext;
  endfunction

  // 6-bit two's complement to sign-magnitude Q3.2. The sum is bounded to
  // -30..+30, so the magnitude always fits in five bits and the most negative
  // two's complement value (-32) can never appear. Zero has sign bit 0, so
  // the result can never be -0.
  function automatic logic [5:0] tc_to_sm(input logic [5:0] tc);
    logic [5:0] mag;
    mag = tc[5] ? (~tc + 6'd1) : tc;
    return {tc[5], mag[4:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic       s1_valid;
  logic [5:0] s1_ta;
  logic [5:0] s1_tb;
  logic       out_stall;
  logic       in_accept;

  // The output register is blocked only when it holds a result nobody takes.
  assign out_stall = out_valid && !out_ready;

  // Stage 1 can take new data if it is empty, or if its current contents are
  // moving into stage 2 this cycle. Deliberately independent of in_valid so
  // the upstream handshake has no combinational loop through this block.
  assign in_ready  = !s1_valid || !out_stall;
  assign in_accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: operand conversion register
  // ---------------------------------------------------------------------------
  logic [5:0] ta_next;
  logic [5:0] tb_next;

  assign ta_next = sm_to_tc(a, 1'b0);
  assign tb_next = sm_to_tc(b, 1'b1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and stage order inside the block cannot matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ta    <= '0;
      s1_tb    <= '0;
    end else if (in_ready) begin
      // A free slot with no incoming operand empties the stage.
      s1_valid <= in_valid;
      if (in_accept) begin
        s1_ta <= ta_next;
        s1_tb <= tb_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: add and convert back, output register
  // ---------------------------------------------------------------------------
  logic [5:0] sum;
  logic [5:0] c_next;

  // NOTE: every signal driven here is given a value on every path, with the
  // plain assignments first, so no latch can be inferred.
  always_comb begin
    sum    = s1_ta + s1_tb;
    c_next = tc_to_sm(sum);
  end

  // NOTE: the data registers are reset as well as the valid bits, so c reads
  // zero from reset until the first real result rather than an unknown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      c         <= '0;
    end else if (!out_stall) begin
      out_valid <= s1_valid;
      // Only real results are loaded; c keeps its last value across bubbles.
      if (s1_valid) begin
        c <= c_next;
      end
    end
  end

endmodule

// File: tb/tb_sm_subtractor_q22.sv
// -----------------------------------------------------------------------------
// tb_sm_subtractor_q22
//
// Directed self-checking bench for sm_subtractor_q22. Inputs are driven and
// outputs sampled 1 ns after each rising clock edge. Expected values are
// hand-computed constants, plus a small integer reference model for the
// random back-to-back phase.
// -----------------------------------------------------------------------------
module tb_sm_subtractor_q22;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] a;
  logic [4:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] c;

  int tests;
  int failed;

  logic [5:0] exp_q[$];

  sm_subtractor_q22 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the sequence is fixed-length, but never let the run hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running, required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("FAIL %s: observed %b required %b", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: integer values of sign-magnitude operands, then re-encode.
  function automatic logic [5:0] ref_sub(input logic [4:0] ra, input logic [4:0] rb);
    int va, vb, d;
    va = ra[4] ? -int'(ra[3:0]) : int'(ra[3:0]);
    vb = rb[4] ? -int'(rb[3:0]) : int'(rb[3:0]);
    d  = va - vb;
    if (d < 0) return {1'b1, 5'(-d)};
    return {1'b0, 5'(d)};
  endfunction

  // One isolated operation with out_ready=1: accept, then result one edge later.
  task automatic single_op(input string tag, input logic [4:0] op_a, input logic [4:0] op_b,
                           input logic [5:0] expected);
    a        = op_a;
    b        = op_b;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, 8'(in_ready), 8'(1'b1));
    tick();
    in_valid = 1'b0;
    tick();
    check({tag, "_out_valid"}, 8'(out_valid), 8'(1'b1));
    check({tag, "_c"}, 8'(c), 8'(expected));
    tick();
    check({tag, "_drained"}, 8'(out_valid), 8'(1'b0));
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 5'b0_0110;
    b         = 5'b0_0010;
    out_ready = 1'b1;

    // ---- Reset with in_valid held high ----
    tick();
    tick();
    check("rst_out_valid", 8'(out_valid), 8'(1'b0));
    check("rst_c", 8'(c), 8'(6'b000000));
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    check("rst_in_ready", 8'(in_ready), 8'(1'b1));
    tick();
    check("rst_idle_out_valid", 8'(out_valid), 8'(1'b0));
    check("rst_idle_c", 8'(c), 8'(6'b000000));

    // ---- Basic results ----
    single_op("pos",      5'b0_0110, 5'b0_0010, 6'b0_00100); //  1.5 - 0.5  =  1.0
    single_op("neg",      5'b0_0010, 5'b0_0110, 6'b1_00100); //  0.5 - 1.5  = -1.0
    single_op("extreme",  5'b1_1111, 5'b0_1111, 6'b1_11110); // -3.75 - 3.75 = -7.5
    single_op("extreme2", 5'b0_1111, 5'b1_1111, 6'b0_11110); //  3.75 + 3.75 = 7.5
    single_op("zero",     5'b0_0101, 5'b0_0101, 6'b0_00000);
    single_op("negzero",  5'b1_0000, 5'b1_0000, 6'b0_00000);
    single_op("negzero2", 5'b1_0000, 5'b1_0011, 6'b0_00011); //  -0 - -0.75 = 0.75
    single_op("negneg",   5'b1_0011, 5'b1_0011, 6'b0_00000); // -0.75 - -0.75 = +0

    // ---- Backpressure: three ops, out_ready low ----
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 5'b0_0100; b = 5'b0_0001;                       // 1 - 0.25
    check("bp_op1_in_ready", 8'(in_ready), 8'(1'b1));
    tick();
    a = 5'b0_1000; b = 5'b0_0010;                       // 2 - 0.5
    check("bp_op2_in_ready", 8'(in_ready), 8'(1'b1));
    tick();
    a = 5'b0_1100; b = 5'b0_0011;                       // 3 - 0.75
    check("bp_full_in_ready", 8'(in_ready), 8'(1'b0));
    check("bp_full_out_valid", 8'(out_valid), 8'(1'b1));
    check("bp_full_c", 8'(c), 8'(6'b0_00011));
    tick();
    check("bp_hold_in_ready", 8'(in_ready), 8'(1'b0));
    check("bp_hold_out_valid", 8'(out_valid), 8'(1'b1));
    check("bp_hold_c", 8'(c), 8'(6'b0_00011));
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 8'(in_ready), 8'(1'b1));
    tick();                                              // op1 leaves, op3 enters
    in_valid = 1'b0;
    check("bp_res2_out_valid", 8'(out_valid), 8'(1'b1));
    check("bp_res2_c", 8'(c), 8'(6'b0_00110));
    tick();
    check("bp_res3_out_valid", 8'(out_valid), 8'(1'b1));
    check("bp_res3_c", 8'(c), 8'(6'b0_01001));
    tick();
    check("bp_drained", 8'(out_valid), 8'(1'b0));

    // ---- Mid-stream reset with two ops in flight ----
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 5'b0_0100; b = 5'b0_0001;
    tick();
    a = 5'b0_1000; b = 5'b0_0010;
    tick();
    in_valid = 1'b0;
    check("mid_full_out_valid", 8'(out_valid), 8'(1'b1));
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 8'(out_valid), 8'(1'b0));
    check("mid_rst_c", 8'(c), 8'(6'b000000));
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mid_rst_in_ready", 8'(in_ready), 8'(1'b1));
    tick();
    check("mid_rst_no_stale", 8'(out_valid), 8'(1'b0));
    single_op("post_rst", 5'b0_0110, 5'b0_0010, 6'b0_00100);

    // ---- Eight random back-to-back ops, full throughput ----
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        a        = 5'($urandom_range(0, 31));
        b        = 5'($urandom_range(0, 31));
        in_valid = 1'b1;
        exp_q.push_back(ref_sub(a, b));
        check($sformatf("tp_in_ready_%0d", i), 8'(in_ready), 8'(1'b1));
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        check($sformatf("tp_out_valid_%0d", i - 1), 8'(out_valid), 8'(1'b1));
        check($sformatf("tp_c_%0d", i - 1), 8'(c), 8'(exp_q.pop_front()));
      end
    end
    tick();
    check("tp_drained", 8'(out_valid), 8'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
